// File: rtl/ex13_frame_acc_pkg.sv
// ex13_pkg: constants shared by the frame accumulator and its helpers.
//   ST_ACC / ST_HOLD   : state encoding (collecting / summary presented)
//   EX13_DATA_W        : width of one pipeline result sample
//   EX13_MIN_INIT      : starting value of the running minimum
//   EX13_MAX_INIT      : starting value of the running maximum
package ex13_pkg;

    localparam logic ST_ACC  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    localparam int EX13_DATA_W = 16;

    localparam logic [EX13_DATA_W-1:0] EX13_MIN_INIT = 16'hFFFF;
    localparam logic [EX13_DATA_W-1:0] EX13_MAX_INIT = 16'h0000;

endpackage

// File: rtl/ex13_frame_acc_sat_add.sv
// ex13_sat_add: purely combinational unsigned saturating adder.
//   a, b : W-bit unsigned operands
//   sum  : a + b, clamped at 2^W - 1
//   ovf  : high when the true sum did not fit and was clamped
module ex13_sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign ovf = raw[W];
    assign sum = ovf ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/ex13_frame_acc.sv
// ex13_frame_acc: collects FRAME_LEN pipeline results into a frame summary
// (saturating sum, min, max, count, saturation flag) and presents it on a
// valid/ready port. The upstream cannot stall, so anything offered while a
// summary is pending is dropped and counted in drop_cnt.
//
// Handshake: a sample is taken on a rising edge where in_valid && in_ready;
// the summary is taken on a rising edge where out_valid && out_ready, and
// every out_* field is held stable while out_valid is high.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid, in_data   : pipeline result stream (16-bit unsigned)
//   in_flush            : close the current partial frame early
//   in_ready            : high while collecting (state ACC)
//   out_valid/out_ready : summary handshake
//   out_sum/min/max     : frame statistics
//   out_count, out_sat  : samples in frame, sum was clamped this frame
//   drop_cnt            : samples dropped while not ready, saturates at 255
module ex13_frame_acc
    import ex13_pkg::*;
#(
    parameter  int FRAME_LEN = 8,
    parameter  int SUM_W     = 24,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [EX13_DATA_W-1:0] in_data,
    input  logic                   in_flush,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_W-1:0]       out_sum,
    output logic [EX13_DATA_W-1:0] out_min,
    output logic [EX13_DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_sat,
    output logic [7:0]             drop_cnt
);

    logic                   state;
    logic [SUM_W-1:0]       sum_q;
    logic [EX13_DATA_W-1:0] min_q;
    logic [EX13_DATA_W-1:0] max_q;
    logic [CNT_W-1:0]       count_q;
    logic                   sat_q;
    logic [7:0]             drop_q;

    logic                   accept;
    logic                   drop;
    logic [SUM_W-1:0]       add_sum;
    logic                   add_ovf;
    logic [CNT_W-1:0]       count_inc;
    logic                   close_frame;

    ex13_sat_add #(.W(SUM_W)) u_sat_add (
        .a   (sum_q),
        .b   ({{(SUM_W - EX13_DATA_W){1'b0}}, in_data}),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign accept    = in_valid && (state == ST_ACC);
    assign drop      = in_valid && (state == ST_HOLD);
    assign count_inc = count_q + 1'b1;

    // A flush closes the frame only if it would not be empty; a sample
    // accepted in the same cycle as the flush belongs to the closing frame.
    assign close_frame = (accept && (count_inc == CNT_W'(FRAME_LEN)))
                      || ((state == ST_ACC) && in_flush && (accept || (count_q != '0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_ACC;
            sum_q   <= '0;
            min_q   <= EX13_MIN_INIT;
            max_q   <= EX13_MAX_INIT;
            count_q <= '0;
            sat_q   <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            if (state == ST_ACC) begin
                if (accept) begin
                    sum_q   <= add_sum;
                    sat_q   <= sat_q | add_ovf;
                    count_q <= count_inc;
                    if (in_data < min_q) min_q <= in_data;
                    if (in_data > max_q) max_q <= in_data;
                end
                if (close_frame) begin
                    state <= ST_HOLD;
                end
            end else if (out_ready) begin
                state   <= ST_ACC;
                sum_q   <= '0;
                min_q   <= EX13_MIN_INIT;
                max_q   <= EX13_MAX_INIT;
                count_q <= '0;
                sat_q   <= 1'b0;
            end
        end
    end

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign out_sum   = sum_q;
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = count_q;
    assign out_sat   = sat_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ex13_frame_acc.sv
// Bench for ex13_frame_acc: a default instance (SUM_W=24) and a narrow
// instance (SUM_W=17) share one input stream; a frame-level model built
// from a sample queue predicts every output after every clock edge.
module tb_ex13_frame_acc;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data  = 16'd0;
    logic        in_flush = 1'b0;
    logic        out_ready = 1'b0;

    logic             rdy_a, val_a, sat_a;
    logic [23:0]      sum_a;
    logic [15:0]      min_a, max_a;
    logic [CNT_W-1:0] cnt_a;
    logic [7:0]       drop_a;

    logic             rdy_b, val_b, sat_b;
    logic [16:0]      sum_b;
    logic [15:0]      min_b, max_b;
    logic [CNT_W-1:0] cnt_b;
    logic [7:0]       drop_b;

    ex13_frame_acc #(.FRAME_LEN(FRAME_LEN), .SUM_W(24)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_flush(in_flush), .in_ready(rdy_a), .out_valid(val_a),
        .out_ready(out_ready), .out_sum(sum_a), .out_min(min_a),
        .out_max(max_a), .out_count(cnt_a), .out_sat(sat_a), .drop_cnt(drop_a)
    );

    ex13_frame_acc #(.FRAME_LEN(FRAME_LEN), .SUM_W(17)) dut17 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_flush(in_flush), .in_ready(rdy_b), .out_valid(val_b),
        .out_ready(out_ready), .out_sum(sum_b), .out_min(min_b),
        .out_max(max_b), .out_count(cnt_b), .out_sat(sat_b), .drop_cnt(drop_b)
    );

    // scoreboard state
    int total = 0;
    int bad   = 0;

    logic [15:0] frame_q[$];
    logic        m_hold = 1'b0;
    int          m_drop = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame model: the pending frame is the list of accepted samples.
    task automatic model_update(input logic r, input logic v, input logic [15:0] d,
                                input logic f, input logic rdy);
        if (r) begin
            m_hold = 1'b0;
            frame_q.delete();
            m_drop = 0;
        end else if (!m_hold) begin
            if (v) frame_q.push_back(d);
            if (frame_q.size() == FRAME_LEN || (f && frame_q.size() > 0)) m_hold = 1'b1;
        end else begin
            if (v && m_drop < 255) m_drop++;
            if (rdy) begin
                m_hold = 1'b0;
                frame_q.delete();
            end
        end
    endtask

    task automatic compare_all();
        longint tot = 0;
        longint max24 = (64'd1 << 24) - 1;
        longint max17 = (64'd1 << 17) - 1;
        int mn = 16'hFFFF;
        int mx = 0;
        foreach (frame_q[i]) begin
            tot += frame_q[i];
            if (int'(frame_q[i]) < mn) mn = frame_q[i];
            if (int'(frame_q[i]) > mx) mx = frame_q[i];
        end
        check("in_ready",  32'(rdy_a),  32'(!m_hold));
        check("out_valid", 32'(val_a),  32'(m_hold));
        check("count",     32'(cnt_a),  32'(frame_q.size()));
        check("sum24",     32'(sum_a),  32'((tot > max24) ? max24 : tot));
        check("sat24",     32'(sat_a),  32'(tot > max24));
        check("min",       32'(min_a),  32'(mn));
        check("max",       32'(max_a),  32'(mx));
        check("drop",      32'(drop_a), 32'(m_drop));
        check("valid17",   32'(val_b),  32'(m_hold));
        check("sum17",     32'(sum_b),  32'((tot > max17) ? max17 : tot));
        check("sat17",     32'(sat_b),  32'(tot > max17));
        check("drop17",    32'(drop_b), 32'(m_drop));
    endtask

    // driver: inputs change 1 time unit after an edge, outputs are
    // compared 1 time unit after the next edge.
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic f, input logic rdy);
        reset = r; in_valid = v; in_data = d; in_flush = f; out_ready = rdy;
        @(posedge clk);
        model_update(r, v, d, f, rdy);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 16'd0, 1'b0, rdy);
    endtask

    initial begin
        // reset values
        step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_min",   32'(min_a), 32'hFFFF);
        check("rst_max",   32'(max_a), 32'h0);
        check("rst_sum",   32'(sum_a), 32'h0);

        // full frame 1..8 with out_ready high, one drop in the HOLD cycle
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i), 1'b0, 1'b1);
        check("f1_valid", 32'(val_a), 32'd1);
        check("f1_sum",   32'(sum_a), 32'd36);
        check("f1_min",   32'(min_a), 32'd1);
        check("f1_max",   32'(max_a), 32'd8);
        check("f1_count", 32'(cnt_a), 32'd8);
        check("f1_sat",   32'(sat_a), 32'd0);
        step(1'b0, 1'b1, 16'd9, 1'b0, 1'b1);
        check("f1_drop",  32'(drop_a), 32'd1);
        check("f1_clear", 32'(val_a),  32'd0);

        // flush alongside the third sample
        step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0);
        check("fl_valid", 32'(val_a), 32'd1);
        check("fl_count", 32'(cnt_a), 32'd3);
        check("fl_sum",   32'(sum_a), 32'h35);
        check("fl_min",   32'(min_a), 32'h05);
        check("fl_max",   32'(max_a), 32'h20);
        idle(1'b1);

        // saturation in the 17-bit instance only
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        check("sat_sum17", 32'(sum_b), 32'h1FFFF);
        check("sat_flag17", 32'(sat_b), 32'd1);
        check("sat_sum24", 32'(sum_a), 32'h7FFF8);
        idle(1'b1);
        step(1'b0, 1'b1, 16'd1, 1'b0, 1'b0);
        check("sat_next17", 32'(sat_b), 32'd0);
        step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        idle(1'b1);

        // long back-pressure with in_valid high
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
        check("bp_sum",   32'(sum_a),  32'd828);
        check("bp_drop",  32'(drop_a), 32'd255);
        idle(1'b1);
        check("bp_count", 32'(cnt_a), 32'd0);
        check("bp_clean", 32'(sum_a), 32'd0);

        // reset mid-frame
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'(7 * i + 3), 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        check("mr_valid", 32'(val_a),  32'd0);
        check("mr_count", 32'(cnt_a),  32'd0);
        check("mr_min",   32'(min_a),  32'hFFFF);
        check("mr_drop",  32'(drop_a), 32'd0);

        // empty flush is ignored
        step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        check("ef_valid", 32'(val_a), 32'd0);
        check("ef_ready", 32'(rdy_a), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex13_frame_acc.md
# ex13_frame_acc

Downstream consumer of the 16-bit multiply-add pipeline result stream. Accepts one result per cycle and accumulates a frame of `FRAME_LEN` samples into a saturating sum with min/max tracking. Presents the frame summary over a valid/ready handshake. The upstream pipeline cannot stall, so samples arriving while a summary is pending are dropped and counted.

## Interface
- `FRAME_LEN`, default 8: samples per frame; minimum 1.
- `SUM_W`, default 24: accumulator width; minimum 17.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `in_data` carries a pipeline result this cycle.
- `in_data`  in  16  unsigned pipeline result (`g`).
- `in_flush`  in  1  close the current partial frame early.
- `in_ready`  out  1  block is accepting samples (state ACC).
- `out_valid`  out  1  frame summary valid.
- `out_ready`  in  1  consumer takes the summary.
- `out_sum`  out  `SUM_W`  saturating sum of accepted samples.
- `out_min`  out  16  minimum accepted sample.
- `out_max`  out  16  maximum accepted sample.
- `out_count`  out  `$clog2(FRAME_LEN+1)`  samples in the frame.
- `out_sat`  out  1  sum clamped at least once this frame.
- `drop_cnt`  out  8  samples dropped while not ready; saturates at 255.

## Operation
- States: ACC (collecting), HOLD (summary presented).
- `in_ready` = (state == ACC); decoded directly from the state register.
- Accept: sample is taken when `in_valid && in_ready` at a clock edge.
- On accept:
  - count += 1.
  - sum = sat_add(sum, zero-extended `in_data`). Result clamps at 2^SUM_W−1; `out_sat` is set and sticky until the frame clears.
  - min = min(min, data); max = max(max, data).
- ACC→HOLD when either:
  - the accepted sample makes count == `FRAME_LEN`; or
  - `in_flush` is high with (count > 0 or a sample accepted that cycle). A sample accepted in the flush cycle is included.
- `in_flush` with count == 0 and no accept: ignored.
- HOLD: all `out_*` fields stay stable while `out_valid` = 1.
- HOLD→ACC on `out_valid && out_ready`. Next cycle: sum = 0, count = 0, min = 0xFFFF, max = 0x0000, sat = 0.
- Drops: `in_valid && !in_ready` increments `drop_cnt`, saturating at 255. This includes the handshake cycle. Only `reset` clears `drop_cnt`.
- `in_flush` in HOLD: ignored.
- Reset mid-frame or mid-HOLD: partial frame is discarded, no summary is emitted, and `drop_cnt` clears.

## Timing
- Reset values:
  - state ACC, `in_ready` 1, `out_valid` 0.
  - `out_sum` 0, `out_min` 0xFFFF, `out_max` 0x0000.
  - `out_count` 0, `out_sat` 0, `drop_cnt` 0.
- Latency: `out_valid` rises the cycle after the closing sample or flush edge, with that sample already reflected in the outputs.
- `out_valid` falls the cycle after the handshake edge. `in_ready` rises in the same cycle.
- Minimum frame period: `FRAME_LEN` + 1 cycles with `out_ready` tied high, so one sample per frame is dropped. This is intended; the consumer must size `FRAME_LEN` accordingly.
- No combinational path from any input to any output.

## Structure
- Shared package `ex13_pkg` holds:
  - state encoding constants (ACC = 1'b0, HOLD = 1'b1);
  - `EX13_DATA_W` = 16;
  - min/max initial constants 16'hFFFF and 16'h0000.
- One sub-module, `ex13_sat_add`: parameterized width; unsigned saturating adder returning sum and overflow flag; purely combinational.

## Test plan
- Reset, then 8 samples 0x0001..0x0008 back-to-back, `out_ready` = 1:
  - `out_valid` asserts 1 cycle after the 8th sample;
  - sum 36, min 1, max 8, count 8, sat 0;
  - sample offered in the HOLD cycle → `drop_cnt` = 1.
- 3 samples 0x0010, 0x0005, 0x0020, with `in_flush` asserted alongside the third: summary count 3, sum 0x35, min 0x05, max 0x20.
- `SUM_W` = 17, 8 samples of 0xFFFF: sum clamps at 0x1FFFF, `out_sat` = 1. Next frame after the handshake reports sat 0.
- Hold `out_ready` low for 300 cycles with `in_valid` high:
  - summary stays stable;
  - `drop_cnt` saturates at 255;
  - on release, the next frame starts clean.
- Assert `reset` for 1 cycle after 5 accepted samples: no summary is emitted; all outputs return to reset values the next cycle.
- `in_flush` with count 0 and `in_valid` low: no state change, `out_valid` stays 0.
